// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam int PC_INCR      = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small power-of-two FIFO of {pc, instr} entries with flush
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fq_entry_t     head
);
    fq_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM, PC mux and decode queue (optional FETCH_PERF_EN counters)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetched,
    output logic [XLEN-1:0] perf_killed
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] addr_nxt;
    logic [XLEN-1:0] pc_incr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;
    logic            push;
    logic            pop;
    logic            space;
    logic            discard;
    fq_entry_t       push_data;
    fq_entry_t       head;

    assign pc_incr   = pc_cur + XLEN'(PC_INCR);
    assign imem_req  = (state == S_REQ) || (state == S_KILL);
    assign id_valid  = (count != '0);
    assign pop       = id_valid & id_ready;
    assign push      = (state == S_REQ) & imem_ack & ~redirect_valid;
    assign discard   = imem_ack & (((state == S_REQ) & redirect_valid) | (state == S_KILL));
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign space     = (count_nxt < CW'(FQ_DEPTH));
    assign push_data = '{pc: imem_addr, instr: imem_rdata};
    assign id_instr  = head.instr;
    assign id_pc     = head.pc;

    // The PC register loads every cycle, so holding means feeding pc_cur back.
    always_comb begin
        pc_next = pc_cur;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if ((state == S_REQ) && imem_ack) begin
            pc_next = pc_incr;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = imem_addr;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && space) begin
                    state_nxt = S_REQ;
                    addr_nxt  = pc_cur;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    state_nxt = imem_ack ? S_IDLE : S_KILL;
                end else if (imem_ack) begin
                    if (space) begin
                        addr_nxt = pc_incr;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_KILL: begin
                // A fresh redirect on the dying ack's cycle leaves pc_cur stale, so re-issue from idle.
                if (imem_ack) begin
                    if (!redirect_valid && space) begin
                        state_nxt = S_REQ;
                        addr_nxt  = pc_cur;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            imem_addr <= addr_nxt;
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
        end else begin
            perf_fetched <= perf_fetched + XLEN'(push);
            perf_killed  <= perf_killed + XLEN'(discard);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with imem model and in-order PC scoreboard
module tb_fetch_unit;
    localparam int          FQ_DEPTH = 2;
    localparam int          CW       = $clog2(FQ_DEPTH) + 1;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_killed;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          pop_count = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] last_pop_pc = '0;
    logic        prev_pend = 1'b0;
    logic [31:0] prev_addr = '0;

    bit          rand_mode = 1'b0;
    int          fixed_delay = 0;
    bit          slow_en = 1'b0;
    logic [31:0] slow_addr = '0;
    int          slow_dly = 0;
    int          wcnt = 0;
    int          cur_rand = 0;
    int          mem_dly = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_killed    (perf_killed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: loads unconditionally every clock.
    always @(posedge clk) pc_cur <= pc_next;

    // Instruction memory: acks each request after a per-request wait, data = addr ^ key.
    always @(negedge clk) begin
        if (!imem_req) begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end else begin
            if (wcnt == 0) cur_rand = $urandom_range(0, 3);
            mem_dly = (slow_en && imem_addr == slow_addr) ? slow_dly :
                      (rand_mode ? cur_rand : fixed_delay);
            if (wcnt >= mem_dly) begin
                imem_ack = 1'b1;
                wcnt     = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end
        imem_rdata = imem_addr ^ XOR_KEY;
    end

    // Reference: decode must see consecutive PCs from the last redirect target, each with its memory word.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            exp_pc    = RESET_PC;
            prev_pend = 1'b0;
        end else begin
            if (id_valid && id_ready) begin
                n_checks++;
                if (id_pc !== exp_pc || id_instr !== (exp_pc ^ XOR_KEY)) begin
                    n_fail++;
                    $display("FAIL scoreboard: got pc=%h instr=%h, want pc=%h instr=%h",
                             id_pc, id_instr, exp_pc, exp_pc ^ XOR_KEY);
                end
                last_pop_pc = id_pc;
                exp_pc      = exp_pc + 32'd4;
                pop_count++;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            if (prev_pend && imem_req) begin
                n_checks++;
                if (imem_addr !== prev_addr) begin
                    n_fail++;
                    $display("FAIL addr_stable: got %h, want %h", imem_addr, prev_addr);
                end
            end
            prev_pend = imem_req && !imem_ack;
            prev_addr = imem_addr;
            n_checks++;
            if (dut.u_queue.push && dut.u_queue.count == CW'(FQ_DEPTH)) begin
                n_fail++;
                $display("FAIL push_full: push with count=%0d, want count<%0d", dut.u_queue.count, FQ_DEPTH);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        id_ready = ready;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, want 0", imem_req); end
        n_checks++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h, want %h", imem_addr, RESET_PC); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b, want 0", id_valid); end
        n_checks++; if (id_instr !== 32'h0) begin n_fail++; $display("FAIL reset_id_instr: got %h, want 0", id_instr); end
        n_checks++; if (id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_id_pc: got %h, want 0", id_pc); end
        n_checks++; if (pc_next !== RESET_PC) begin n_fail++; $display("FAIL reset_pc_next: got %h, want %h", pc_next, RESET_PC); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'h0) begin n_fail++; $display("FAIL reset_perf_fetched: got %0d, want 0", perf_fetched); end
        n_checks++; if (perf_killed !== 32'h0) begin n_fail++; $display("FAIL reset_perf_killed: got %0d, want 0", perf_killed); end
`endif
    endtask

    task automatic test_stream();
        fixed_delay = 0;
        do_reset(1'b1);
        n_checks++; if (pc_next !== RESET_PC) begin n_fail++; $display("FAIL stream_pc0: got %h, want %h", pc_next, RESET_PC); end
        for (int i = 1; i <= 16; i++) begin
            cyc();
            n_checks++;
            if (pc_next !== pc_cur + 32'd4) begin
                n_fail++;
                $display("FAIL stream_pc_next[%0d]: got %h, want %h", i, pc_next, pc_cur + 32'd4);
            end
            if (i >= 2) begin
                n_checks++;
                if (id_valid !== 1'b1) begin n_fail++; $display("FAIL stream_every_cycle[%0d]: id_valid=%b, want 1", i, id_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        int p0;
        fixed_delay = 0;
        do_reset(1'b0);
        for (int i = 1; i <= 10; i++) cyc();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b, want 0", imem_req); end
        n_checks++; if (pc_cur !== 32'h8) begin n_fail++; $display("FAIL bp_pc_cur: got %h, want 8", pc_cur); end
        n_checks++; if (pc_next !== 32'h8) begin n_fail++; $display("FAIL bp_pc_next: got %h, want 8", pc_next); end
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: valid=%b pc=%h, want 1/0", id_valid, id_pc); end
        p0 = pop_count;
        @(negedge clk);
        id_ready = 1'b1;
        #1;
        cyc();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin n_fail++; $display("FAIL bp_resume: req=%b addr=%h, want 1/8", imem_req, imem_addr); end
        n_checks++; if (id_pc !== 32'h4) begin n_fail++; $display("FAIL bp_second: id_pc=%h, want 4", id_pc); end
        for (int i = 0; i < 4; i++) cyc();
        #3;
        n_checks++; if (pop_count - p0 != 6) begin n_fail++; $display("FAIL bp_pops: got %0d, want 6", pop_count - p0); end
    endtask

    task automatic test_ack_delay();
        int  waits = 0;
        bit  seen = 1'b0;
        slow_en = 1'b1; slow_addr = 32'h10; slow_dly = 3;
        do_reset(1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (imem_req && imem_addr == 32'h10) begin
                if (!imem_ack) begin
                    waits++;
                    n_checks++;
                    if (pc_next !== pc_cur) begin n_fail++; $display("FAIL delay_hold_pc: got %h, want %h", pc_next, pc_cur); end
                end else begin
                    seen = 1'b1;
                    break;
                end
            end
        end
        n_checks++; if (!seen || waits != 3) begin n_fail++; $display("FAIL delay_waits: got %0d (ack seen %b), want 3", waits, seen); end
        slow_en = 1'b0;
    endtask

    task automatic test_redirect_kill();
        int  p0;
        bit  found = 1'b0;
`ifdef FETCH_PERF_EN
        logic [31:0] k0;
`endif
        slow_en = 1'b1; slow_addr = 32'h20; slow_dly = 2;
        do_reset(1'b1);
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            found = imem_req && imem_addr == 32'h20 && !imem_ack;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL kill_setup: request to 0x20 not seen, want seen"); end
`ifdef FETCH_PERF_EN
        k0 = perf_killed;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL kill_pc_next: got %h, want 100", pc_next); end
        #2;
        p0 = pop_count;
        cyc();
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL kill_flush: id_valid=%b, want 0", id_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin n_fail++; $display("FAIL kill_hold: req=%b addr=%h, want 1/20", imem_req, imem_addr); end
        cyc();
        n_checks++; if (imem_ack !== 1'b1 || pc_next !== 32'h100) begin n_fail++; $display("FAIL kill_ack: ack=%b pc_next=%h, want 1/100", imem_ack, pc_next); end
        for (int i = 0; i < 20 && pop_count == p0; i++) begin cyc(); #3; end
        n_checks++; if (pop_count == p0 || last_pop_pc !== 32'h100) begin n_fail++; $display("FAIL kill_next_pc: got %h, want 100", last_pop_pc); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_killed - k0 !== 32'd1) begin n_fail++; $display("FAIL kill_perf: got %0d, want 1", perf_killed - k0); end
`endif
        slow_en = 1'b0;
    endtask

    task automatic test_redirect_ack();
        int  p0;
        bit  found = 1'b0;
`ifdef FETCH_PERF_EN
        logic [31:0] k0;
`endif
        fixed_delay = 0;
        do_reset(1'b1);
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            found = imem_req && imem_addr == 32'h20 && imem_ack;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL racc_setup: ack to 0x20 not seen, want seen"); end
`ifdef FETCH_PERF_EN
        k0 = perf_killed;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        n_checks++; if (pc_next !== 32'h100) begin n_fail++; $display("FAIL racc_pc_next: got %h, want 100", pc_next); end
        #2;
        p0 = pop_count;
        cyc();
        n_checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL racc_idle: req=%b valid=%b, want 0/0", imem_req, id_valid); end
        cyc();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL racc_addr: req=%b addr=%h, want 1/100", imem_req, imem_addr); end
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_killed - k0 !== 32'd1) begin n_fail++; $display("FAIL racc_perf: got %0d, want 1", perf_killed - k0); end
`endif
        for (int i = 0; i < 20 && pop_count == p0; i++) begin cyc(); #3; end
        n_checks++; if (pop_count == p0 || last_pop_pc !== 32'h100) begin n_fail++; $display("FAIL racc_next_pc: got %h, want 100", last_pop_pc); end
    endtask

    task automatic test_wrap();
        bit found = 1'b0;
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            found = imem_req && imem_addr == 32'hFFFF_FFFC && imem_ack;
        end
        n_checks++; if (!found || pc_next !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_next: got %h (ack seen %b), want 0", pc_next, found); end
        cyc();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: req=%b addr=%h, want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        slow_en = 1'b1; slow_addr = 32'h4; slow_dly = 6;
        do_reset(1'b0);
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            found = imem_req && imem_addr == 32'h4 && id_valid && !imem_ack;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rmid_setup: outstanding request with valid head not seen, want seen"); end
        rst = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_async: req=%b valid=%b, want 0/0", imem_req, id_valid); end
        n_checks++; if (pc_next !== RESET_PC) begin n_fail++; $display("FAIL rmid_pc_next: got %h, want %h", pc_next, RESET_PC); end
        n_checks++; if (id_pc !== 32'h0 || id_instr !== 32'h0) begin n_fail++; $display("FAIL rmid_head: pc=%h instr=%h, want 0/0", id_pc, id_instr); end
        slow_en = 1'b0;
        do_reset(1'b1);
    endtask

    task automatic test_random();
        int p0;
        rand_mode = 1'b1;
        do_reset(1'b1);
        p0 = pop_count;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            redirect_valid = 1'b0;
            id_ready = ($urandom_range(0, 3) != 0);
            #1;
            if ($urandom_range(0, 15) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = $urandom() & 32'hFFFF_FFFC;
            end
        end
        #3;
        n_checks++; if (pop_count - p0 < 300) begin n_fail++; $display("FAIL random_progress: got %0d pops, want >=300", pop_count - p0); end
        rand_mode = 1'b0;
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_ack_delay();
        test_redirect_kill();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
